// File: rtl/pulse_tx_pkg.sv
// Shared types and default timing constants for the pulse-width transmitter.
`timescale 1ns/1ps
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned CYCLES_PER_US = 100;
  localparam int unsigned DEF_MIN_HIGH  = CYCLES_PER_US;
  localparam int unsigned DEF_MIN_LOW   = 100;
  localparam int unsigned DEF_WIDTH_W   = 16;

endpackage

// File: rtl/pwtx_counter.sv
// Loadable down-counter with a registered zero flag; times both HIGH and GAP.
`timescale 1ns/1ps
module pwtx_counter
  import pulse_tx_pkg::*;
#(
  parameter int unsigned WIDTH_W = DEF_WIDTH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [WIDTH_W-1:0] count;

  // Load wins over enable; the counter saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (en && (count != '0)) begin
      count <= count - WIDTH_W'(1);
      zero  <= (count == WIDTH_W'(1));
    end
  end

endmodule

// File: rtl/pulse_width_tx.sv
// Pulse generator with minimum high time and enforced low gap for the glitch filter.
// Optional short-pulse injection is built when PULSE_TX_GLITCH_INJ_EN is defined.
`timescale 1ns/1ps
module pulse_width_tx
  import pulse_tx_pkg::*;
#(
  parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
  parameter int unsigned MIN_LOW  = DEF_MIN_LOW,
  parameter int unsigned WIDTH_W  = DEF_WIDTH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [WIDTH_W-1:0] req_width,
  output logic               req_ready,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               clamp_evt
`ifdef PULSE_TX_GLITCH_INJ_EN
  ,
  input  logic               inj_valid,
  input  logic [7:0]         inj_len
`endif
);

  localparam logic [WIDTH_W-1:0] MIN_HIGH_W = WIDTH_W'(MIN_HIGH);
  localparam logic [WIDTH_W-1:0] MIN_LOW_W  = WIDTH_W'(MIN_LOW);

  state_e             state_q, state_d;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [WIDTH_W-1:0] cnt_val;
  logic [WIDTH_W-1:0] req_eff;
  logic               done_d, clamp_d;

  // Counter is loaded with length-1 so the zero flag marks the final cycle.
  assign req_eff = (req_width < MIN_HIGH_W) ? MIN_HIGH_W : req_width;

`ifdef PULSE_TX_GLITCH_INJ_EN
  localparam logic [WIDTH_W-1:0] INJ_CAP_W = WIDTH_W'(MIN_HIGH - 1);
  logic               inj_q, inj_d;
  logic [WIDTH_W-1:0] inj_len_w, inj_eff;
  assign inj_len_w = WIDTH_W'(inj_len);
  assign inj_eff   = (inj_len_w < INJ_CAP_W) ? inj_len_w : INJ_CAP_W;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    done_d   = 1'b0;
    clamp_d  = 1'b0;
`ifdef PULSE_TX_GLITCH_INJ_EN
    inj_d    = inj_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
          cnt_val  = req_eff - WIDTH_W'(1);
          clamp_d  = (req_width < MIN_HIGH_W);
`ifdef PULSE_TX_GLITCH_INJ_EN
          inj_d    = 1'b0;
        end else if (inj_valid && req_ready) begin
          inj_d = 1'b1;
          if (inj_eff != '0) begin
            state_d  = HIGH;
            cnt_load = 1'b1;
            cnt_val  = inj_eff - WIDTH_W'(1);
          end
`endif
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = MIN_LOW_W - WIDTH_W'(1);
`ifdef PULSE_TX_GLITCH_INJ_EN
          done_d   = !inj_q;
`else
          done_d   = 1'b1;
`endif
        end
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all outputs registered together from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      clamp_evt <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      pulse_out <= (state_d == HIGH);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      clamp_evt <= clamp_d;
    end
  end

`ifdef PULSE_TX_GLITCH_INJ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inj_q <= 1'b0;
    else        inj_q <= inj_d;
  end
`endif

  pwtx_counter #(
    .WIDTH_W (WIDTH_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

endmodule
